// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready handshakes.
// The accumulate adder is a chain of 4-bit carry-lookahead cells with the carry rippled between cells.

module cla_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // Lookahead carries expanded from generate/propagate terms
  always_comb begin
    g_s    = a & b;
    p_s    = a ^ b;
    c_s[0] = c_in;
    c_s[1] = g_s[0] | (p_s[0] & c_in);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & c_in);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);
    sum    = p_s ^ c_s[3:0];
    c_out  = c_s[4];
  end

endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int SLICES = WIDTH / 4;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] acc_hi_r;
  logic [WIDTH-1:0] acc_lo_r;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] next_hi_s;
  logic [WIDTH-1:0] next_lo_s;
  logic             carry_s;

  // Per-slice carry nets keep the ripple chain free of a self-referencing vector
  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    logic c_in_s;
    logic c_out_s;
    if (i == 0) begin : g_lsb
      assign c_in_s = 1'b0;
    end else begin : g_chain
      assign c_in_s = g_slice[i-1].c_out_s;
    end
    cla_adder4 u_cla (
      .a     (acc_hi_r[4*i +: 4]),
      .b     (addend_s[4*i +: 4]),
      .c_in  (c_in_s),
      .sum   (sum_s[4*i +: 4]),
      .c_out (c_out_s)
    );
  end

  assign carry_s = g_slice[SLICES-1].c_out_s;

  // One shift-add step: the adder carry lands in the top bit of the shifted accumulator
  always_comb begin
    if (acc_lo_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    next_hi_s = {carry_s, sum_s[WIDTH-1:1]};
    next_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == BUSY);
  assign out_valid = (state_r == DONE);

  // Handshake FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      acc_hi_r <= {WIDTH{1'b0}};
      acc_lo_r <= {WIDTH{1'b0}};
      product  <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= in_a;
            acc_lo_r <= in_b;
            acc_hi_r <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          acc_hi_r <= next_hi_s;
          acc_lo_r <= next_lo_s;
          count_r  <= count_r + CW'(1);
          if (count_r == LAST_STEP) begin
            product <= {next_hi_s, next_lo_s};
            state_r <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at WIDTH=8 and WIDTH=16.
// Shared stimulus is steered to one instance at a time by sel16.

module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sel16;
  logic [15:0] in_a;
  logic [15:0] in_b;

  logic        rdy8, ov8, busy8;
  logic [15:0] prod8;
  logic        rdy16, ov16, busy16;
  logic [31:0] prod16;

  logic        rdy, ov, bsy;
  logic [31:0] prod;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel16), .in_ready(rdy8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .product(prod8), .busy(busy8)
  );

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel16), .in_ready(rdy16),
    .in_a(in_a), .in_b(in_b), .out_valid(ov16), .out_ready(out_ready),
    .product(prod16), .busy(busy16)
  );

  assign rdy  = sel16 ? rdy16  : rdy8;
  assign ov   = sel16 ? ov16   : ov8;
  assign bsy  = sel16 ? busy16 : busy8;
  assign prod = sel16 ? prod16 : {16'h0000, prod8};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; hold = DONE cycles with out_ready low, noise = in_valid pulses while busy
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int hold, input bit noise);
    int  lat;
    bit  busy_ok;
    @(negedge clk);
    out_ready = 1'b0;
    in_a = {8'h00, a};
    in_b = {8'h00, b};
    in_valid = 1'b1;
    check_value("idle_in_ready", rdy, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!ov && lat < 40) begin
      if (!bsy || rdy) busy_ok = 1'b0;
      if (noise) begin
        in_valid = lat[0];
        in_a = 16'h0055;
        in_b = 16'h00AA;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_value("latency", lat, 8);
    check_value("busy_during_op", busy_ok, 1);
    check_value("product", prod, {16'h0000, exp});
    check_value("done_flags", {rdy, bsy, ov}, 3'b001);
    for (int k = 0; k < hold; k++) begin
      in_valid = noise;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      check_value("held_product", prod, {16'h0000, exp});
      check_value("held_valid", {rdy, ov}, 2'b01);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_value("back_to_idle", {rdy, bsy, ov}, 3'b100);
    check_value("product_kept", prod, {16'h0000, exp});
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    in_a = 16'h00FF;
    in_b = 16'h00FF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_value("midrst_flags", {rdy, bsy, ov}, 3'b100);
    check_value("midrst_product", prod, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_random(input int w, input int n);
    int          last_acc;
    int          wait_n;
    logic [31:0] a, b, mask;
    mask = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
    last_acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = $urandom & mask;
      b = $urandom & mask;
      in_a = a[15:0];
      in_b = b[15:0];
      in_valid = 1'b1;
      wait_n = 0;
      while (!rdy && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      check_value("rand_accept", rdy, 1);
      if (i > 0) check_value("rand_spacing", cyc - last_acc, w + 2);
      last_acc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      wait_n = 0;
      while (!ov && wait_n < 40) begin
        @(negedge clk);
        wait_n++;
      end
      check_value("rand_product", prod, a * b);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sel16 = 1'b0;
    in_a = 16'h0000;
    in_b = 16'h0000;
    repeat (2) @(negedge clk);
    check_value("reset_flags", {rdy, bsy, ov}, 3'b100);
    check_value("reset_product", prod, 32'h0);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 16'h008F, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
    run_op(8'h00, 8'h5A, 16'h0000, 0, 1'b0);
    run_op(8'h01, 8'hA7, 16'h00A7, 0, 1'b0);
    run_op(8'h80, 8'h80, 16'h4000, 0, 1'b0);
    run_op(8'h12, 8'h34, 16'h03A8, 5, 1'b1);
    reset_mid_op();
    run_op(8'd3, 8'd5, 16'h000F, 0, 1'b0);

    run_random(8, 1000);
    @(negedge clk);
    sel16 = 1'b1;
    @(negedge clk);
    check_value("w16_idle", {rdy, bsy, ov}, 3'b100);
    run_random(16, 1000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned WIDTH x WIDTH multiplier. It uses radix-2 shift-and-add, one partial-product step per clock. Its accumulate adder is built from chained 4-bit carry-lookahead adder cells (claAdder4, WIDTH/4 slices, carry rippled between slices), so it directly consumes the CLA stage's sum and carry-out. Operands enter and the product leaves through valid/ready handshakes, which lets the block sit between an operand source and a result consumer in the multiplier datapath.

Parameters:
WIDTH, 8, operand width in bits. Must be a multiple of 4 and at least 4. The product is 2*WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands; high only in IDLE
in_a  input  WIDTH  multiplicand, unsigned
in_b  input  WIDTH  multiplier, unsigned
out_valid  output  1  product valid; high only in DONE
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  unsigned product, registered
busy  output  1  high in BUSY state

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n), as already decided.
- Reset (rst_n=0, any state) forces:
  - state=IDLE, count=0, acc=0, mcand=0, product=0
  - out_valid=0, busy=0, in_ready=1 (decoded from IDLE)
- Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- Registers: mcand[WIDTH], acc_hi[WIDTH], acc_lo[WIDTH] (holds the multiplier, shifts out LSB-first), count[clog2(WIDTH+1)].
- FSM IDLE:
  - Accept when in_valid & in_ready.
  - On accept: mcand<=in_a, acc_lo<=in_b, acc_hi<=0, count<=0, go to BUSY.
- FSM BUSY, each cycle:
  - addend = acc_lo[0] ? mcand : 0.
  - {c,sum} = acc_hi + addend, computed through the CLA slice chain with c_in=0; c is the final slice carry-out.
  - {acc_hi,acc_lo} <= {c,sum,acc_lo[WIDTH-1:1]}, a logical right shift of the (2*WIDTH+1)-bit value.
  - count<=count+1.
  - When the step completing count==WIDTH-1 executes: product<={next acc_hi,next acc_lo}, go to DONE.
- FSM DONE:
  - out_valid=1; product held stable.
  - On out_ready=1: go to IDLE, out_valid drops next cycle.
  - out_ready held low: stay in DONE indefinitely, product and out_valid unchanged.
- Latency:
  - Accept at edge E puts out_valid high after edge E+WIDTH, i.e. exactly WIDTH BUSY cycles.
  - Fixed latency, no early termination on zero operands.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH steps, output handshake, back in IDLE).
- in_valid in BUSY/DONE is ignored (in_ready=0). Operands need not be held after the accept edge.
- Arithmetic: unsigned only. Intermediate acc_hi+addend never exceeds WIDTH+1 bits; the carry is retained via the shift, never dropped. The final product always fits 2*WIDTH bits, with no overflow.
- product changes only on the transition into DONE or on reset. It is not cleared on leaving DONE.
- in_ready and out_valid are never high together.

Test Plan:
- WIDTH=8, reset then in_a=13, in_b=11 accepted -> out_valid high exactly 8 cycles after accept; product=16'h008F; busy high for those 8 cycles.
- Max operands in_a=8'hFF, in_b=8'hFF -> product=16'hFE01; exercises the carry-out of every CLA slice and its retention in the shift.
- Zero/identity cases: 0x00*0x5A -> 16'h0000; 0x01*0xA7 -> 16'h00A7; 0x80*0x80 -> 16'h4000; all with the same fixed 8-cycle latency.
- Backpressure: 0x12*0x34 with out_ready low 5 cycles after out_valid -> product=16'h03A8 held stable, out_valid held; in_valid pulses during BUSY/DONE ignored (in_ready=0); IDLE one cycle after out_ready=1.
- Reset mid-op: accept 0xFF*0xFF, assert rst_n=0 at BUSY step 4 -> immediately out_valid=0, busy=0, product=0, in_ready=1; a new op 3*5 afterwards -> product=16'h000F.
- Random back-to-back: 1000 random pairs with out_ready held high, WIDTH=8 and WIDTH=16 -> each product equals a*b per a reference model; successive accepts spaced exactly WIDTH+2 cycles apart.
